dcsk_tx_sequencer: RTL and testbench
====================================

DCSK_TX_SEQUENCER -- requirements
Module: dcsk_tx_sequencer

Interface
REQ-001 The block SHALL have parameter MSG_WIDTH, default 32, giving message bits per frame (≥2).
REQ-002 The block SHALL have parameter GUARD_CHIPS, default 4, giving idle chips after each frame (≥1).
REQ-003 Clock and reset SHALL be a single clock i_clk and a synchronous, active-high reset i_rst; all state SHALL change only on the rising edge of i_clk.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_valid, in, 1, frame request.
- o_ready, out, 1, sequencer can accept a frame.
- i_msg, in, MSG_WIDTH, message to send.
- i_spreading_factor, in, 2, SF code: 00=SF2, 01=SF4, 10=SF8, 11=SF16.
- i_abort, in, 1, terminate current frame.
- o_msg, out, MSG_WIDTH, captured message.
- o_spreading_factor, out, 2, captured SF code.
- o_load_msg, out, 1, one-cycle load strobe to the modulator.
- o_is_sending, out, 1, high during chip transmission.
- o_chip_idx_msb, out, 1, 0 = reference half, 1 = data half.
- o_bit_idx, out, $clog2(MSG_WIDTH), index of the current bit.
- o_done, out, 1, one-cycle pulse at normal frame completion.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, SEND and GUARD; all outputs SHALL be registered or decoded from registered state only.
REQ-006 o_ready SHALL be 1 exactly when the state is IDLE and i_rst is low.
REQ-007 In IDLE, i_valid & o_ready SHALL capture i_msg into o_msg and i_spreading_factor into o_spreading_factor, then go to LOAD; IDLE with i_valid low SHALL hold.
REQ-008 o_msg and o_spreading_factor SHALL remain stable from capture until the next capture; input changes outside a capture SHALL be ignored.
REQ-009 In LOAD, which lasts exactly 1 cycle, o_load_msg SHALL be 1; the next state SHALL be SEND with chip_cnt=0 and bit_cnt=0.
REQ-010 Let N = 2^(code+1), giving N of 2, 4, 8 or 16; each bit SHALL span 2N chips, one chip per clock.
REQ-011 In SEND, o_is_sending SHALL be 1 and chip_cnt SHALL increment every cycle.
REQ-012 In SEND, o_chip_idx_msb SHALL be 0 for chip_cnt 0..N-1 and 1 for chip_cnt N..2N-1.
REQ-013 When chip_cnt = 2N-1, chip_cnt SHALL wrap to 0 and bit_cnt SHALL increment.
REQ-014 If chip_cnt = 2N-1 and bit_cnt = MSG_WIDTH-1, the next state SHALL be GUARD and bit_cnt SHALL not wrap.
REQ-015 o_bit_idx SHALL equal bit_cnt in SEND and 0 elsewhere.
REQ-016 A frame SHALL contain exactly MSG_WIDTH*2N SEND cycles, with o_chip_idx_msb producing exactly MSG_WIDTH falling edges inside SEND.
REQ-017 In GUARD, o_is_sending and o_chip_idx_msb SHALL be 0, and a counter SHALL run GUARD_CHIPS cycles.
REQ-018 On the last GUARD cycle, the next state SHALL be IDLE and o_done SHALL pulse for 1 cycle on the first IDLE cycle.
REQ-019 From IDLE, o_ready SHALL return 1 in that same cycle.
REQ-020 A new frame MAY be accepted in that same cycle.
REQ-021 The gap between consecutive LOAD pulses SHALL be 1 + MSG_WIDTH*2N + GUARD_CHIPS + 1 cycles when i_valid is held high.
REQ-022 i_abort in LOAD, SEND or GUARD SHALL force IDLE on the next edge and clear all counters.
REQ-023 After i_abort, o_is_sending, o_chip_idx_msb and o_load_msg SHALL be 0 from the next cycle.
REQ-024 o_done SHALL NOT pulse for an aborted frame.
REQ-025 i_abort in IDLE SHALL take precedence over i_valid, so no capture occurs.
REQ-026 The chip and bit counters SHALL be wide enough for SF16, so that chip_cnt reaches a maximum of 31 without overflow.

Reset
REQ-027 While i_rst is high, the state SHALL be IDLE and all counters SHALL be 0.
REQ-028 While i_rst is high, o_msg, o_spreading_factor, o_load_msg, o_is_sending, o_chip_idx_msb, o_bit_idx, o_done and o_ready SHALL all be 0.
REQ-029 i_rst asserted mid-frame SHALL abort the frame exactly as REQ-022 does, except that outputs are 0 in the reset cycle itself.
REQ-030 o_ready SHALL be 1 on the first cycle after i_rst falls.

Verification
REQ-031 The bench SHALL cover: SF2, MSG_WIDTH=32, msg=0xA5A5_0F0F -> 1 LOAD pulse, 128 SEND cycles, msb pattern 0,0,1,1 repeated 32 times, 4 GUARD cycles, 1 o_done.
REQ-032 The bench SHALL cover: SF16, one frame -> 1024 SEND cycles, msb low 16 / high 16 per bit, o_bit_idx stepping 0..31.
REQ-033 The bench SHALL cover: back-to-back frames with i_valid held high, SF4 then SF8 -> second capture on the o_done cycle, LOAD spacing 1+256+4+1=262 cycles, and o_spreading_factor=01 throughout frame 1.
REQ-034 The bench SHALL cover: i_abort at SEND cycle 37 -> IDLE next cycle, o_is_sending=0, no o_done, and o_ready=1.
REQ-035 The bench SHALL cover: i_rst pulsed for 1 cycle during GUARD -> all outputs 0 in the reset cycle, o_ready=1 afterwards, no o_done.
REQ-036 The bench SHALL cover: i_msg and i_spreading_factor toggled during SEND -> o_msg and o_spreading_factor unchanged until the next capture.

Source files
------------

// File: rtl/dcsk_tx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dcsk_tx_sequencer                                          |
// | Description : Frame sequencer for a DCSK transmitter. It captures one    |
// |               message and spreading-factor code per frame, strobes the   |
// |               modulator load, then steps through the reference and data  |
// |               chip halves of every message bit. Each frame ends with a   |
// |               fixed idle guard interval.                                 |
// | Ports       : i_clk, i_rst             clock, sync active-high reset     |
// |               i_valid / o_ready        frame request handshake           |
// |               i_msg, i_spreading_factor frame contents (captured)        |
// |               i_abort                  terminate the current frame       |
// |               o_msg, o_spreading_factor captured frame contents          |
// |               o_load_msg               one-cycle modulator load strobe   |
// |               o_is_sending             chip transmission in progress     |
// |               o_chip_idx_msb           0 = reference half, 1 = data half |
// |               o_bit_idx                current message bit               |
// |               o_done                   normal frame completion pulse     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dcsk_tx_sequencer #(
  parameter int MSG_WIDTH   = 32,
  parameter int GUARD_CHIPS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [MSG_WIDTH-1:0]         i_msg,
  input  logic [1:0]                   i_spreading_factor,
  input  logic                         i_abort,
  output logic [MSG_WIDTH-1:0]         o_msg,
  output logic [1:0]                   o_spreading_factor,
  output logic                         o_load_msg,
  output logic                         o_is_sending,
  output logic                         o_chip_idx_msb,
  output logic [$clog2(MSG_WIDTH)-1:0] o_bit_idx,
  output logic                         o_done
);

  localparam int c_BIT_W   = $clog2(MSG_WIDTH);
  // +1 keeps the width at least one bit when GUARD_CHIPS is 1
  localparam int c_GUARD_W = $clog2(GUARD_CHIPS + 1);
  localparam logic [c_BIT_W-1:0]   c_LAST_BIT   = c_BIT_W'(MSG_WIDTH - 1);
  localparam logic [c_GUARD_W-1:0] c_LAST_GUARD = c_GUARD_W'(GUARD_CHIPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [4:0]             chip_cnt_q,  chip_cnt_d;   // up to 31 for SF16
  logic [c_BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [c_GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [MSG_WIDTH-1:0]   msg_q,       msg_d;
  logic [1:0]             sf_q,        sf_d;
  logic                   done_q,      done_d;

  logic [5:0]             w_half_chips;  // N chips per half-bit
  logic [4:0]             w_last_chip;   // 2N-1

  always_comb begin
    w_half_chips = 6'd2 << sf_q;
    w_last_chip  = 5'((w_half_chips << 1) - 6'd1);
  end

  always_comb begin
    state_d     = state_q;
    chip_cnt_d  = chip_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    guard_cnt_d = guard_cnt_q;
    msg_d       = msg_q;
    sf_d        = sf_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort in IDLE blocks the capture
        if (i_valid && !i_abort) begin
          msg_d   = i_msg;
          sf_d    = i_spreading_factor;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        chip_cnt_d = 5'd0;
        bit_cnt_d  = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (chip_cnt_q == w_last_chip) begin
          chip_cnt_d = 5'd0;
          if (bit_cnt_q == c_LAST_BIT) begin
            // last bit: leave bit_cnt at its final value, no wrap
            guard_cnt_d = '0;
            state_d     = ST_GUARD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          chip_cnt_d = chip_cnt_q + 5'd1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == c_LAST_GUARD) begin
          guard_cnt_d = '0;
          bit_cnt_d   = '0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      chip_cnt_d  = 5'd0;
      bit_cnt_d   = '0;
      guard_cnt_d = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      chip_cnt_q  <= 5'd0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      msg_q       <= '0;
      sf_q        <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_cnt_q  <= chip_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      msg_q       <= msg_d;
      sf_q        <= sf_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode registered state; i_rst forces them low in the reset
  // cycle itself, before the synchronous clear has taken effect.
  always_comb begin
    o_ready            = (state_q == ST_IDLE) && !i_rst;
    o_msg              = i_rst ? '0 : msg_q;
    o_spreading_factor = i_rst ? 2'd0 : sf_q;
    o_load_msg         = (state_q == ST_LOAD) && !i_rst;
    o_is_sending       = (state_q == ST_SEND) && !i_rst;
    o_chip_idx_msb     = o_is_sending && ({1'b0, chip_cnt_q} >= w_half_chips);
    o_bit_idx          = o_is_sending ? bit_cnt_q : '0;
    o_done             = done_q && !i_rst;
  end

endmodule
`default_nettype wire

// File: tb/tb_dcsk_tx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dcsk_tx_sequencer                                       |
// | Description : Self-checking bench for dcsk_tx_sequencer: a vector table, |
// |               directed frame scenarios and randomized traffic checked    |
// |               against a frame-timeline reference model.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dcsk_tx_sequencer;

  localparam int c_MSG_WIDTH   = 32;
  localparam int c_GUARD_CHIPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] msg = 32'h0;
  logic [1:0]  sf = 2'd0;
  logic        o_ready, o_load_msg, o_is_sending, o_chip_idx_msb, o_done;
  logic [31:0] o_msg;
  logic [1:0]  o_spreading_factor;
  logic [4:0]  o_bit_idx;

  always #5 clk = ~clk;

  dcsk_tx_sequencer #(
    .MSG_WIDTH  (c_MSG_WIDTH),
    .GUARD_CHIPS(c_GUARD_CHIPS)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_valid           (valid),
    .o_ready           (o_ready),
    .i_msg             (msg),
    .i_spreading_factor(sf),
    .i_abort           (abort),
    .o_msg             (o_msg),
    .o_spreading_factor(o_spreading_factor),
    .o_load_msg        (o_load_msg),
    .o_is_sending      (o_is_sending),
    .o_chip_idx_msb    (o_chip_idx_msb),
    .o_bit_idx         (o_bit_idx),
    .o_done            (o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline t = 0 (LOAD), 1..W*2N (SEND),
  // then GUARD_CHIPS guard cycles; completion shows o_done in the next IDLE.
  bit          m_busy = 1'b0;
  int          m_t = 0;
  logic [31:0] m_msg = '0;
  logic [1:0]  m_sf = '0;
  bit          m_done = 1'b0;

  function automatic logic [43:0] model_expect();
    logic r, l, s, m;
    logic [4:0] b;
    int n, send_len, k;
    if (rst) return '0;
    n        = 2 << m_sf;
    send_len = c_MSG_WIDTH * 2 * n;
    r = !m_busy;
    l = m_busy && (m_t == 0);
    s = m_busy && (m_t >= 1) && (m_t <= send_len);
    m = 1'b0;
    b = 5'd0;
    if (s) begin
      k = m_t - 1;
      b = 5'(k / (2 * n));
      m = (k % (2 * n)) >= n;
    end
    return {r, l, s, m, b, m_done, m_sf, m_msg};
  endfunction

  function automatic void model_update();
    int total;
    if (rst) begin
      m_busy = 0; m_t = 0; m_msg = '0; m_sf = '0; m_done = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (valid && !abort) begin
        m_busy = 1; m_t = 0; m_msg = msg; m_sf = sf;
      end
    end else begin
      total = 1 + c_MSG_WIDTH * 2 * (2 << m_sf) + c_GUARD_CHIPS;
      if (abort) begin
        m_busy = 0; m_done = 0;
      end else if (m_t == total - 1) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_t++;
      end
    end
  endfunction

  // Per-scenario statistics observed on the DUT outputs
  int n_load, n_send, n_guard, n_done, n_fall, n_msb_hi, max_bit;
  int cyc = 0, last_load = -1, last_gap = 0, done_cyc = -1;
  logic prev_msb = 1'b0, prev_send = 1'b0;

  task automatic clear_stats();
    n_load = 0; n_send = 0; n_guard = 0; n_done = 0; n_fall = 0;
    n_msb_hi = 0; max_bit = 0; last_load = -1; last_gap = 0; done_cyc = -1;
  endtask

  // One clock: inputs already driven; check mid-cycle, advance model at edge.
  task automatic cycle();
    #1;
    chk("outputs",
        {20'd0, o_ready, o_load_msg, o_is_sending, o_chip_idx_msb, o_bit_idx,
         o_done, o_spreading_factor, o_msg},
        {20'd0, model_expect()});
    if (o_load_msg) begin
      n_load++;
      if (last_load >= 0) last_gap = cyc - last_load;
      last_load = cyc;
    end
    if (o_is_sending) begin
      n_send++;
      if (o_chip_idx_msb) n_msb_hi++;
      if (int'(o_bit_idx) > max_bit) max_bit = int'(o_bit_idx);
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (prev_send && prev_msb && !o_chip_idx_msb) n_fall++;
    if (!rst && !o_ready && !o_load_msg && !o_is_sending) n_guard++;
    prev_msb  = o_chip_idx_msb;
    prev_send = o_is_sending;
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; abort = 1'b0;
    cycle();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic start_frame(input logic [1:0] code, input logic [31:0] m);
    valid = 1'b1; sf = code; msg = m;
    cycle();
    valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("done_reached", 64'(n_done), 64'd1);
  endtask

  typedef struct {
    logic        rst, valid, abort;
    logic [1:0]  sf;
    logic [31:0] msg;
    logic [4:0]  exp_ctl;  // {ready, load, send, msb, done}
    logic [31:0] exp_msg;
    logic [1:0]  exp_sf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad;
    logic [31:0] m1, m2, keep;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd3, 32'hDEADBEEF, 5'b00000, 32'h0,        2'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b10000, 32'h0,        2'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 5'b10000, 32'h0,        2'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b10000, 32'h0,        2'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h11223344, 5'b10000, 32'h0,        2'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h55555555, 5'b01000, 32'h11223344, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00100, 32'h11223344, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00100, 32'h11223344, 2'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00100, 32'h11223344, 2'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00100, 32'h11223344, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00110, 32'h11223344, 2'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        5'b00110, 32'h11223344, 2'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        5'b10000, 32'h11223344, 2'd1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        5'b00000, 32'h0,        2'd0};

    // Bring the DUT out of its unknown power-up state
    rst = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // Table-driven vectors: reset, abort-over-valid, SF4 capture, abort
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; valid = tbl[i].valid; abort = tbl[i].abort;
      sf = tbl[i].sf; msg = tbl[i].msg;
      #1;
      chk($sformatf("tbl%0d_ctl", i),
          64'({o_ready, o_load_msg, o_is_sending, o_chip_idx_msb, o_done}),
          64'(tbl[i].exp_ctl));
      chk($sformatf("tbl%0d_msg", i), 64'(o_msg), 64'(tbl[i].exp_msg));
      chk($sformatf("tbl%0d_sf", i), 64'(o_spreading_factor), 64'(tbl[i].exp_sf));
      cycle();
    end

    // SF2 frame with the reference message
    do_reset();
    start_frame(2'd0, 32'hA5A5_0F0F);
    run_until_done(200);
    cycle(); cycle();
    chk("sf2_loads", 64'(n_load), 64'd1);
    chk("sf2_send", 64'(n_send), 64'd128);
    chk("sf2_msb_hi", 64'(n_msb_hi), 64'd64);
    chk("sf2_falls", 64'(n_fall), 64'd32);
    chk("sf2_guard", 64'(n_guard), 64'd4);
    chk("sf2_done", 64'(n_done), 64'd1);
    chk("sf2_msg", 64'(o_msg), 64'hA5A5_0F0F);

    // SF16 frame
    do_reset();
    start_frame(2'd3, $urandom);
    run_until_done(1100);
    chk("sf16_send", 64'(n_send), 64'd1024);
    chk("sf16_msb_hi", 64'(n_msb_hi), 64'd512);
    chk("sf16_falls", 64'(n_fall), 64'd32);
    chk("sf16_max_bit", 64'(max_bit), 64'd31);

    // Back-to-back frames, SF4 then SF8, i_valid held high
    do_reset();
    m1 = $urandom; m2 = $urandom;
    valid = 1'b1; sf = 2'd1; msg = m1;
    k = 0; bad = 0;
    while (n_load < 2 && k < 600) begin
      cycle();
      if (k == 0) begin sf = 2'd2; msg = m2; end
      if (n_load == 1 && !o_ready && !o_load_msg && o_spreading_factor != 2'd1) bad++;
      k++;
    end
    chk("b2b_loads", 64'(n_load), 64'd2);
    chk("b2b_gap", 64'(last_gap), 64'd262);
    chk("b2b_capture_on_done", 64'(last_load - done_cyc), 64'd1);
    chk("b2b_sf1_stable", 64'(bad), 64'd0);
    chk("b2b_sf2", 64'(o_spreading_factor), 64'd2);
    chk("b2b_msg2", 64'(o_msg), 64'(m2));
    valid = 1'b0; abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Abort at SEND cycle 37
    do_reset();
    start_frame(2'd2, $urandom);
    k = 0;
    while (n_send < 37 && k < 100) begin cycle(); k++; end
    chk("abort_reach", 64'(n_send), 64'd37);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_sending", 64'(o_is_sending), 64'd0);
    chk("abort_msb", 64'(o_chip_idx_msb), 64'd0);
    chk("abort_load", 64'(o_load_msg), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    repeat (300) cycle();
    chk("abort_no_done", 64'(n_done), 64'd0);

    // Reset pulse during GUARD
    do_reset();
    start_frame(2'd0, $urandom);
    k = 0;
    while (n_guard < 2 && k < 300) begin cycle(); k++; end
    chk("rst_guard_reach", 64'(n_guard), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst_outputs_zero",
        64'({o_ready, o_load_msg, o_is_sending, o_chip_idx_msb, o_bit_idx,
             o_done, o_spreading_factor, o_msg}), 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 64'(o_ready), 64'd1);
    repeat (20) cycle();
    chk("rst_no_done", 64'(n_done), 64'd0);

    // Inputs toggled during the frame are ignored
    do_reset();
    keep = 32'h3C3C_9696;
    start_frame(2'd0, keep);
    bad = 0;
    k = 0;
    while (n_done == 0 && k < 200) begin
      msg = $urandom; sf = 2'($urandom_range(0, 3));
      cycle();
      if (o_msg != keep || o_spreading_factor != 2'd0) bad++;
      k++;
    end
    chk("hold_done", 64'(n_done), 64'd1);
    chk("hold_stable", 64'(bad), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      abort = ($urandom_range(0, 99) == 0);
      valid = 1'($urandom_range(0, 1));
      sf    = 2'($urandom_range(0, 3));
      msg   = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
